// File: rtl/sensor_scanner.sv
// sensor_scanner: walks a shared 4-channel ADC through req/ack and publishes the four readings atomically.
// Define SENSOR_SCANNER_FRAME_CNT_EN to add the frame_cnt output (completed frames, wraps at 255).
module sensor_scanner #(
   parameter int unsigned SAMPLE_W = 8,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned SCAN_GAP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                clear_err,
   output logic                adc_req,
   output logic [1:0]          adc_ch,
   input  logic                adc_ack,
   input  logic [SAMPLE_W-1:0] adc_data,
   output logic [SAMPLE_W-1:0] sensor1,
   output logic [SAMPLE_W-1:0] sensor2,
   output logic [SAMPLE_W-1:0] sensor3,
   output logic [SAMPLE_W-1:0] sensor4,
   output logic                frame_valid,
   output logic                timeout_err,
   output logic                busy
`ifdef SENSOR_SCANNER_FRAME_CNT_EN
   ,
   output logic [7:0]          frame_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, REQ, REL, COMMIT, GAP} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] GAP_LAST  = 8'(SCAN_GAP - 1);
   localparam bit         HAS_GAP   = (SCAN_GAP != 0);

   state_t              state;
   logic [1:0]          ch;
   logic [7:0]          wait_cnt;
   logic [7:0]          gap_cnt;
   logic [SAMPLE_W-1:0] shadow [0:3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ch          <= '0;
         wait_cnt    <= '0;
         gap_cnt     <= '0;
         adc_req     <= 1'b0;
         adc_ch      <= '0;
         sensor1     <= '0;
         sensor2     <= '0;
         sensor3     <= '0;
         sensor4     <= '0;
         frame_valid <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) shadow[i] <= '0;
`ifdef SENSOR_SCANNER_FRAME_CNT_EN
         frame_cnt   <= '0;
`endif
      end else begin
         frame_valid <= 1'b0;
         // a timeout set later in this block overrides the clear
         if (clear_err) timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state    <= REQ;
                  ch       <= '0;
                  adc_ch   <= '0;
                  adc_req  <= 1'b1;
                  wait_cnt <= '0;
                  busy     <= 1'b1;
               end
            end
            REQ: begin
               if (adc_ack) begin
                  adc_req <= 1'b0;
                  if (ch == 2'd3) begin
                     sensor1     <= shadow[0];
                     sensor2     <= shadow[1];
                     sensor3     <= shadow[2];
                     sensor4     <= adc_data;
                     frame_valid <= 1'b1;
                     state       <= COMMIT;
                  end else begin
                     shadow[ch] <= adc_data;
                     ch         <= ch + 2'd1;
                     state      <= REL;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout_err <= 1'b1;
                  adc_req     <= 1'b0;
                  if (HAS_GAP) begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end else if (enable) begin
                     ch       <= '0;
                     adc_ch   <= '0;
                     adc_req  <= 1'b1;
                     wait_cnt <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            REL: begin
               state    <= REQ;
               adc_req  <= 1'b1;
               adc_ch   <= ch;
               wait_cnt <= '0;
            end
            COMMIT: begin
`ifdef SENSOR_SCANNER_FRAME_CNT_EN
               frame_cnt <= frame_cnt + 8'd1;
`endif
               if (HAS_GAP) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end else if (enable) begin
                  state    <= REQ;
                  ch       <= '0;
                  adc_ch   <= '0;
                  adc_req  <= 1'b1;
                  wait_cnt <= '0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (enable) begin
                     state    <= REQ;
                     ch       <= '0;
                     adc_ch   <= '0;
                     adc_req  <= 1'b1;
                     wait_cnt <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: begin
               state   <= IDLE;
               adc_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_scanner.sv
// tb_sensor_scanner: directed latency/boundary cases plus randomized ADC timing against a transaction-level model.
// Define SENSOR_SCANNER_FRAME_CNT_EN to also exercise frame_cnt.
module tb_sensor_scanner;
   localparam int TO   = 15;
   localparam int GAPN = 4;

   logic       clk = 1'b0;
   logic       rst, enable, clear_err, adc_ack;
   logic [7:0] adc_data;
   logic       adc_req;
   logic [1:0] adc_ch;
   logic [7:0] sensor1, sensor2, sensor3, sensor4;
   logic       frame_valid, timeout_err, busy;
`ifdef SENSOR_SCANNER_FRAME_CNT_EN
   logic [7:0] frame_cnt;
`endif

   sensor_scanner #(.SAMPLE_W(8), .TIMEOUT(TO), .SCAN_GAP(GAPN)) dut (
      .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
      .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
      .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
      .frame_valid(frame_valid), .timeout_err(timeout_err), .busy(busy)
`ifdef SENSOR_SCANNER_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // transaction-level model: what the ADC was told, and what must therefore be published
   logic [7:0] pub [4];
   logic [7:0] nxt_pub [4];
   logic [7:0] shadow [4];
   logic [7:0] tab [4];
   int         dly [4];
   int         exp_ch, req_len, plan, low_run, kind, cyc_n;
   bit         dir, spur, fv_next, fv_exp, exp_err, err_next, must_low, pending, en_low_seen, timeout_now;
   bit         cnt_inc;
   logic [7:0] exp_cnt;

   task model_reset();
      for (int i = 0; i < 4; i++) begin pub[i] = '0; shadow[i] = '0; end
      exp_ch = 0; req_len = 0; low_run = 0; kind = 3;
      fv_next = 0; fv_exp = 0; exp_err = 0; err_next = 0;
      must_low = 0; pending = 0; en_low_seen = 0; cnt_inc = 0; exp_cnt = '0;
   endtask

   function automatic int rand_delay();
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 14) return int'($urandom_range(1, 3));
      if (r < 16) return TO;
      if (r < 18) return TO + 1;
      return int'($urandom_range(4, TO - 1));
   endfunction

   task step(input bit clr);
      int gexp;
      @(posedge clk); #1;
      cyc_n++;
      if (fv_next) pub = nxt_pub;
      fv_exp  = fv_next;
      fv_next = 0;
      exp_err = err_next;
      if (cnt_inc) exp_cnt = exp_cnt + 8'd1;
      cnt_inc = fv_exp;
      check("frame_valid", frame_valid, fv_exp);
      check("sensor1", sensor1, pub[0]);
      check("sensor2", sensor2, pub[1]);
      check("sensor3", sensor3, pub[2]);
      check("sensor4", sensor4, pub[3]);
      check("timeout_err", timeout_err, exp_err);
`ifdef SENSOR_SCANNER_FRAME_CNT_EN
      check("frame_cnt", frame_cnt, exp_cnt);
`endif
      if (pending || must_low) check("adc_req", adc_req, pending);
      timeout_now = 0;
      adc_ack  = 1'b0;
      adc_data = 8'($urandom);
      if (adc_req) begin
         req_len++;
         if (req_len == 1) begin
            if (!en_low_seen && kind != 3) begin
               gexp = (kind == 0) ? 1 : (kind == 1) ? GAPN + 1 : GAPN;
               check("req_gap", low_run, gexp);
            end
            en_low_seen = 0;
            plan = dir ? dly[exp_ch] : rand_delay();
         end
         check("adc_ch", adc_ch, exp_ch);
         check("req_len_ok", req_len <= TO, 1);
         low_run  = 0;
         must_low = 0;
         pending  = 1;
         if (req_len == plan) begin
            adc_ack = 1'b1;
            if (dir) adc_data = tab[exp_ch];
            if (exp_ch == 3) begin
               nxt_pub = '{shadow[0], shadow[1], shadow[2], adc_data};
               fv_next = 1;
               kind    = 1;
               exp_ch  = 0;
            end else begin
               shadow[exp_ch] = adc_data;
               exp_ch++;
               kind = 0;
            end
            must_low = 1;
            pending  = 0;
         end else if (req_len == TO) begin
            timeout_now = 1;
            exp_ch   = 0;
            kind     = 2;
            must_low = 1;
            pending  = 0;
         end
      end else begin
         req_len  = 0;
         low_run++;
         must_low = 0;
         pending  = 0;
         if (spur && $urandom_range(0, 3) == 0) adc_ack = 1'b1;
      end
      if (!enable) en_low_seen = 1;
      clear_err = clr;
      err_next  = timeout_now ? 1'b1 : (clr ? 1'b0 : exp_err);
   endtask

   task wait_for(input int what, input int arg, input int limit, input string tag);
      bit hit;
      hit = 0;
      for (int i = 0; i < limit && !hit; i++) begin
         step(0);
         case (what)
            0: hit = frame_valid;
            1: hit = (req_len == 1);
            2: hit = adc_req && (adc_ch == 2'(arg));
            3: hit = !busy;
            default: hit = timeout_err;
         endcase
      end
      check(tag, hit, 1);
   endtask

   initial begin
      int c0, f;
      rst = 1'b1; enable = 1'b0; clear_err = 1'b0; adc_ack = 1'b0; adc_data = '0;
      dir = 1; spur = 0; cyc_n = 0; plan = 0;
      dly = '{1, 1, 1, 1};
      tab = '{8'd10, 8'd20, 8'd30, 8'd40};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", adc_req, 0);
      check("rst_ch", adc_ch, 0);
      check("rst_fv", frame_valid, 0);
      check("rst_err", timeout_err, 0);
      check("rst_busy", busy, 0);
      check("rst_s4", sensor4, 0);
      rst = 1'b0;
      repeat (3) step(0);
      check("idle_busy", busy, 0);
      check("idle_req", adc_req, 0);

      // zero-wait frame and latencies
      enable = 1'b1;
      c0 = cyc_n;
      wait_for(1, 0, 5, "wait_req1");
      check("lat_req", cyc_n - c0, 1);
      wait_for(0, 0, 20, "wait_fv1");
      check("lat_fv", cyc_n - c0, 8);
      check("f1_s1", sensor1, 10);
      check("f1_s2", sensor2, 20);
      check("f1_s3", sensor3, 30);
      check("f1_s4", sensor4, 40);
      f = cyc_n;
      wait_for(1, 0, 10, "wait_req2");
      check("lat_next", cyc_n - f, GAPN + 1);

      // channel 1 never acked: timeout, frame dropped, restart at ch0
      dly[1] = TO + 1;
      tab = '{8'd11, 8'd21, 8'd31, 8'd41};
      wait_for(4, 0, 40, "wait_err");
      check("to_set", timeout_err, 1);
      check("to_keep_s2", sensor2, 20);
      wait_for(1, 0, 10, "wait_restart");
      check("to_restart_ch", adc_ch, 0);
      dly = '{1, 1, 1, 1};
      step(1);
      step(0);
      check("err_clr", timeout_err, 0);
      wait_for(0, 0, 20, "wait_fv3");

      // ack on the last permitted wait cycle
      dly = '{1, TO, 1, 1};
      tab = '{8'd5, 8'd6, 8'd7, 8'd8};
      wait_for(0, 0, 60, "wait_fv4");
      check("edge_s2", sensor2, 6);
      check("edge_err", timeout_err, 0);

      // async reset while channel 2 is requested
      dly = '{1, 1, 5, 1};
      wait_for(2, 2, 40, "wait_ch2");
      #2 rst = 1'b1;
      adc_ack = 1'b0;
      #1;
      check("mid_rst_req", adc_req, 0);
      check("mid_rst_s1", sensor1, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ch", adc_ch, 0);
      check("mid_rst_fv", frame_valid, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      dly = '{1, 1, 1, 1};
      c0 = cyc_n;
      wait_for(1, 0, 5, "wait_rst_req");
      check("rst_restart_lat", cyc_n - c0, 1);
      check("rst_restart_ch", adc_ch, 0);

      // enable dropped mid-frame: frame completes, then IDLE after the gap
      wait_for(2, 1, 10, "wait_ch1");
      enable = 1'b0;
      wait_for(0, 0, 20, "wait_fv5");
      f = cyc_n;
      wait_for(3, 0, 20, "wait_idle");
      check("idle_lat", cyc_n - f, GAPN + 1);
      repeat (3) step(0);
      check("stopped_req", adc_req, 0);
      check("stopped_busy", busy, 0);

      // randomized ADC timing, spurious acks, random clear_err
      dir = 0; spur = 1; enable = 1'b1;
      for (int i = 0; i < 1500; i++) step($urandom_range(0, 7) == 0);
      spur = 0;

`ifdef SENSOR_SCANNER_FRAME_CNT_EN
      rst = 1'b1; adc_ack = 1'b0;
      #1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      dir = 1; dly = '{1, 1, 1, 1};
      for (int i = 0; i < 257; i++) wait_for(0, 0, 30, "wait_cnt_fv");
      dly[2] = TO + 1;
      wait_for(4, 0, 40, "wait_cnt_err");
      check("cnt_after_to", frame_cnt, 1);
`endif

      enable = 1'b0;
      repeat (20) step(0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end
endmodule
